// File: rtl/ula_pkg.sv
// Shared definitions for the post-ALU stage: word widths, flag bit positions,
// operation-class codes, branch-condition encoding and the condition evaluator.
package ula_pkg;

    localparam int BITS_PALAVRA  = 16;
    localparam int BITS_CONTROLE = 5;
    localparam int BITS_REG      = 3;

    // Bit positions inside the {Z,C,N,O} flag register
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

    // Operation class taken from in_controle[4:3]; anything else is logic/constant
    localparam logic [1:0] CLASSE_ARIT = 2'b00;
    localparam logic [1:0] CLASSE_DESL = 2'b01;

    typedef enum logic [3:0] {
        COND_SEMPRE = 4'd0,
        COND_Z      = 4'd1,
        COND_NZ     = 4'd2,
        COND_N      = 4'd3,
        COND_NN     = 4'd4,
        COND_C      = 4'd5,
        COND_NC     = 4'd6,
        COND_O      = 4'd7,
        COND_NO     = 4'd8,
        COND_LT     = 4'd9,
        COND_GT     = 4'd10
    } cond_t;

    typedef struct packed {
        logic [BITS_PALAVRA-1:0] resultado;
        logic [BITS_REG-1:0]     dest;
    } entrada_saida_t;

    // Evaluates a branch condition against a {Z,C,N,O} flag vector.
    // Codes 11..15 are reserved and always evaluate false.
    function automatic logic cond_avalia(input logic [3:0] f, input logic [3:0] sel);
        logic r;
        r = 1'b0;
        case (cond_t'(sel))
            COND_SEMPRE: r = 1'b1;
            COND_Z:      r = f[FLAG_Z];
            COND_NZ:     r = !f[FLAG_Z];
            COND_N:      r = f[FLAG_N];
            COND_NN:     r = !f[FLAG_N];
            COND_C:      r = f[FLAG_C];
            COND_NC:     r = !f[FLAG_C];
            COND_O:      r = f[FLAG_O];
            COND_NO:     r = !f[FLAG_O];
            COND_LT:     r = f[FLAG_N] ^ f[FLAG_O];
            COND_GT:     r = !(f[FLAG_N] ^ f[FLAG_O]) && !f[FLAG_Z];
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/buffer_saida_ula.sv
// Generic 2-entry FIFO with valid/ready on both sides. in_ready is a flop
// (count != 2 after this cycle's push/pop) so it never depends combinationally
// on out_ready.
module buffer_saida_ula #(
    parameter int LARGURA = 19
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LARGURA-1:0] in_dados,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LARGURA-1:0] out_dados
);

    logic [LARGURA-1:0] mem_q [2];
    logic [LARGURA-1:0] mem_d [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         count_q, count_d;
    logic               in_ready_q, in_ready_d;
    logic               push;
    logic               pop;

    assign push      = in_valid && in_ready_q;
    assign pop       = (count_q != 2'd0) && out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign out_dados = mem_q[rd_ptr_q];

    // Next-state for storage, pointers, occupancy and the registered ready
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            mem_d[wr_ptr_q] = in_dados;
            wr_ptr_d        = !wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
        in_ready_d = (count_d != 2'd2);
    end

    // State registers; reset discards contents so the head reads as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: rtl/estagio_pos_ula.sv
// Post-ALU stage: buffers ALU results toward write-back, keeps the {Z,C,N,O}
// flag register with per-class update rules and evaluates branch conditions.
// Optional macro FLAG_BYPASS_EN: cond_ok looks at the next-state flags so a
// flag update accepted this cycle is visible to the branch immediately.
module estagio_pos_ula
    import ula_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BITS_PALAVRA-1:0]  in_resultado,
    input  logic [BITS_CONTROLE-1:0] in_controle,
    input  logic [BITS_REG-1:0]      in_dest,
    input  logic                     in_atualiza_flags,
    input  logic                     in_C,
    input  logic                     in_O,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BITS_PALAVRA-1:0]  out_resultado,
    output logic [BITS_REG-1:0]      out_dest,
    output logic [3:0]               flags,
    input  logic [3:0]               cond_sel,
    output logic                     cond_ok
);

    entrada_saida_t entrada;
    entrada_saida_t saida;
    logic [3:0]     flags_q, flags_d;
    logic           aceita;
    logic           z_local;
    logic           n_local;
    logic           unused_controle;

    // Only the class bits of the control code matter here
    assign unused_controle = &{1'b0, in_controle[2:0]};

    assign entrada.resultado = in_resultado;
    assign entrada.dest      = in_dest;

    buffer_saida_ula #(
        .LARGURA ($bits(entrada_saida_t))
    ) u_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dados  (entrada),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dados (saida)
    );

    assign out_resultado = saida.resultado;
    assign out_dest      = saida.dest;
    assign aceita        = in_valid && in_ready;
    assign z_local       = (in_resultado == '0);
    assign n_local       = in_resultado[BITS_PALAVRA-1];

    // Flag next-state: Z/N always from the result, C/O depend on operation class
    always_comb begin
        flags_d = flags_q;
        if (aceita && in_atualiza_flags) begin
            flags_d[FLAG_Z] = z_local;
            flags_d[FLAG_N] = n_local;
            case (in_controle[4:3])
                CLASSE_ARIT: begin
                    flags_d[FLAG_C] = in_C;
                    flags_d[FLAG_O] = in_O;
                end
                CLASSE_DESL: begin
                    flags_d[FLAG_C] = in_C;
                    flags_d[FLAG_O] = 1'b0;
                end
                default: begin
                    flags_d[FLAG_C] = flags_q[FLAG_C];
                    flags_d[FLAG_O] = flags_q[FLAG_O];
                end
            endcase
        end
    end

    // Architectural flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;

`ifdef FLAG_BYPASS_EN
    assign cond_ok = cond_avalia(flags_d, cond_sel);
`else
    assign cond_ok = cond_avalia(flags_q, cond_sel);
`endif

endmodule

// File: tb/tb_estagio_pos_ula.sv
// Bench for estagio_pos_ula: queue/arithmetic reference model checked every
// cycle, plus literal expectations at key points of the directed sequence.
module tb_estagio_pos_ula;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_resultado;
    logic [4:0]  in_controle;
    logic [2:0]  in_dest;
    logic        in_atualiza_flags;
    logic        in_C;
    logic        in_O;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_resultado;
    logic [2:0]  out_dest;
    logic [3:0]  flags;
    logic [3:0]  cond_sel;
    logic        cond_ok;

    int tests = 0;
    int fails = 0;

    always #5 clk = !clk;

    estagio_pos_ula dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_resultado      (in_resultado),
        .in_controle       (in_controle),
        .in_dest           (in_dest),
        .in_atualiza_flags (in_atualiza_flags),
        .in_C              (in_C),
        .in_O              (in_O),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_resultado     (out_resultado),
        .out_dest          (out_dest),
        .flags             (flags),
        .cond_sel          (cond_sel),
        .cond_ok           (cond_ok)
    );

    // ---------------- reference model ----------------
    logic [18:0] mq[$];
    bit mz, mc, mn, mo;
    int pops = 0;

    function automatic bit model_cond(bit z, bit c, bit n, bit o, int sel);
        case (sel)
            0: return 1;
            1: return z;
            2: return !z;
            3: return n;
            4: return !n;
            5: return c;
            6: return !c;
            7: return o;
            8: return !o;
            9: return n ^ o;
            10: return !(n ^ o) && !z;
            default: return 0;
        endcase
    endfunction

    // Flags the model holds after the current cycle's inputs are applied
    task automatic model_next(output bit z, output bit c, output bit n, output bit o);
        z = mz; c = mc; n = mn; o = mo;
        if (in_valid && mq.size() < 2 && in_atualiza_flags) begin
            z = (in_resultado == 0);
            n = in_resultado[15];
            if (in_controle[4:3] == 2'd0) begin
                c = in_C; o = in_O;
            end else if (in_controle[4:3] == 2'd1) begin
                c = in_C; o = 0;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mz = 0; mc = 0; mn = 0; mo = 0;
        end else begin
            bit z, c, n, o;
            bit pop_now, push_now;
            model_next(z, c, n, o);
            pop_now  = (mq.size() > 0) && out_ready;
            push_now = in_valid && (mq.size() < 2);
            if (pop_now) begin
                void'(mq.pop_front());
                pops++;
            end
            if (push_now) mq.push_back({in_resultado, in_dest});
            mz = z; mc = c; mn = n; mo = o;
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            bit z, c, n, o, ec;
`ifdef FLAG_BYPASS_EN
            model_next(z, c, n, o);
`else
            z = mz; c = mc; n = mn; o = mo;
`endif
            ec = model_cond(z, c, n, o, int'(cond_sel));
            check("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
            check("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
            check("flags", {28'd0, flags}, {28'd0, mz, mc, mn, mo});
            check("cond_ok", {31'd0, cond_ok}, {31'd0, ec});
            if (mq.size() > 0) begin
                check("out_data", {13'd0, out_resultado, out_dest}, {13'd0, mq[0]});
                $display("[TB] t=%0t head res=%h dest=%0d flags=%b", $time, out_resultado, out_dest, flags);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push(input logic [15:0] r, input logic [4:0] ctl, input logic [2:0] d,
                        input logic c, input logic o, input logic upd);
        bit rdy;
        int n;
        in_valid = 1; in_resultado = r; in_controle = ctl; in_dest = d;
        in_C = c; in_O = o; in_atualiza_flags = upd;
        n = 0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 50);
        if (!rdy) begin
            tests++; fails++;
            $display("FAIL push_timeout: in_ready stuck at 0 expected 1");
        end
        #2;
        in_valid = 0;
    endtask

    initial begin
        rst_n = 0; in_valid = 0; in_resultado = 0; in_controle = 0; in_dest = 0;
        in_atualiza_flags = 0; in_C = 0; in_O = 0; out_ready = 0; cond_sel = 0;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_res", {16'd0, out_resultado}, 32'd0);
        check("rst_out_dest", {29'd0, out_dest}, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        check("rst_cond_ok", {31'd0, cond_ok}, 32'd1);
        @(negedge clk);
        rst_n = 1;
        out_ready = 1;
        @(posedge clk); #2;

        // Arithmetic zero result with carry -> Z=1 C=1
        push(16'h0000, 5'b00000, 3'd1, 1, 0, 1);
        @(negedge clk);
        check("lit_valid_after_accept", {31'd0, out_valid}, 32'd1);
        check("lit_flags_arit", {28'd0, flags}, 32'b1100);
        // Shift, negative result -> Z0 C1 N1 O0
        push(16'h8000, 5'b01000, 3'd2, 1, 0, 1);
        @(negedge clk);
        check("lit_flags_desl", {28'd0, flags}, 32'b0110);
        // Logic class: C/O held, N cleared
        push(16'h0001, 5'b10001, 3'd3, 0, 1, 1);
        @(negedge clk);
        check("lit_flags_logic", {28'd0, flags}, 32'b0100);
        // No update when atualiza=0
        push(16'h0000, 5'b00000, 3'd4, 0, 1, 0);
        @(negedge clk);
        check("lit_flags_noupd", {28'd0, flags}, 32'b0100);

        // Conditions with N=1 O=0 Z=0
        push(16'h8000, 5'b10000, 3'd5, 0, 0, 1);
        cond_sel = 9;  @(negedge clk); check("lit_cond9", {31'd0, cond_ok}, 32'd1);
        cond_sel = 10; @(negedge clk); check("lit_cond10", {31'd0, cond_ok}, 32'd0);
        cond_sel = 13; @(negedge clk); check("lit_cond13", {31'd0, cond_ok}, 32'd0);
        cond_sel = 2;  @(negedge clk); check("lit_cond2", {31'd0, cond_ok}, 32'd1);
        cond_sel = 0;

        // Backpressure: three results with write-back stalled
        @(posedge clk); #2;
        out_ready = 0;
        fork
            begin
                push(16'hAAAA, 5'b10000, 3'd1, 0, 0, 0);
                push(16'hBBBB, 5'b10000, 3'd2, 0, 0, 0);
                @(negedge clk);
                check("lit_full_in_ready", {31'd0, in_ready}, 32'd0);
                push(16'hCCCC, 5'b10000, 3'd3, 0, 0, 0);
            end
            begin
                repeat (6) @(posedge clk);
                #2 out_ready = 1;
            end
        join
        repeat (4) @(posedge clk);
        #2;

        // Streaming: 8 back-to-back results with out_ready held high
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            push(16'h1000 + 16'(i), 5'b00000, 3'(i), 0, 0, 1);
        end
        repeat (2) @(posedge clk);
        #2;
        check("lit_stream_pops", pops, 32'd8);

`ifdef FLAG_BYPASS_EN
        // Same-cycle visibility of an accepted zero result
        cond_sel = 1;
        in_valid = 1; in_resultado = 0; in_controle = 0; in_atualiza_flags = 1;
        in_C = 0; in_O = 0; in_dest = 0;
        @(negedge clk);
        check("lit_bypass_cond", {31'd0, cond_ok}, 32'd1);
        @(posedge clk); #2;
        in_valid = 0; cond_sel = 0;
        repeat (2) @(posedge clk);
        #2;
`endif

        // Asynchronous reset with the buffer full
        out_ready = 0;
        push(16'h0005, 5'b00000, 3'd6, 1, 0, 1);
        push(16'h0006, 5'b00000, 3'd7, 1, 0, 1);
        @(negedge clk);
        check("lit_pre_rst_flags", {28'd0, flags}, 32'b0100);
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        check("lit_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("lit_rst_flags", {28'd0, flags}, 32'd0);
        check("lit_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
